// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared CPU constants and types for the PC sequencer
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational fixed-priority next-PC selection
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        boot_i,
    input  logic [31:0] cur_pc_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_hold_o,
    output logic        redirect_o
);

    logic [31:0] raw_pc;

    always_comb begin
        raw_pc     = cur_pc_i + PC_STEP;
        pc_hold_o  = 1'b0;
        redirect_o = 1'b0;
        if (boot_i) begin
            raw_pc = RESET_VECTOR;
        end else if (exc_i) begin
            raw_pc     = EXC_VECTOR;
            redirect_o = 1'b1;
        end else if (eret_i) begin
            raw_pc     = epc_i;
            redirect_o = 1'b1;
        end else if (br_taken_i) begin
            raw_pc     = br_target_i;
            redirect_o = 1'b1;
        end else if (jump_i) begin
            raw_pc     = jump_target_i;
            redirect_o = 1'b1;
        end else if (stall_i) begin
            raw_pc    = cur_pc_i;
            pc_hold_o = 1'b1;
        end
        // Misaligned targets are truncated rather than trapped.
        next_pc_o = word_align(raw_pc);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencing FSM with flush generation and exception PC
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_cur_pc,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exc,
    input  logic        i_eret,
    output logic [31:0] o_next_pc,
    output logic        o_pc_hold,
    output logic        o_flush,
    output logic [31:0] o_epc
);

    seq_state_e  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        boot;
    logic        redirect;

    pc_next_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .EXC_VECTOR   (EXC_VECTOR)
    ) u_next_mux (
        .boot_i        (boot),
        .cur_pc_i      (i_cur_pc),
        .stall_i       (i_stall),
        .br_taken_i    (i_br_taken),
        .br_target_i   (i_br_target),
        .jump_i        (i_jump),
        .jump_target_i (i_jump_target),
        .exc_i         (i_exc),
        .eret_i        (i_eret),
        .epc_i         (epc_q),
        .next_pc_o     (o_next_pc),
        .pc_hold_o     (o_pc_hold),
        .redirect_o    (redirect)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_BOOT;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    // BOOT ignores every request, so exceptions there never capture an epc.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_FLUSH: begin
                state_d = redirect ? ST_FLUSH : ST_RUN;
                if (i_exc) epc_d = i_cur_pc;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        boot    = (state_q == ST_BOOT);
        o_flush = (state_q == ST_FLUSH);
        o_epc   = epc_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cur_pc = 32'h0;
    logic        stall = 1'b0, br = 1'b0, jmp = 1'b0, exc = 1'b0, eret = 1'b0;
    logic [31:0] br_tgt = 32'h0, jmp_tgt = 32'h0;
    logic [31:0] next_pc, epc;
    logic        hold, flush;

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cur_pc      (cur_pc),
        .i_stall       (stall),
        .i_br_taken    (br),
        .i_br_target   (br_tgt),
        .i_jump        (jmp),
        .i_jump_target (jmp_tgt),
        .i_exc         (exc),
        .i_eret        (eret),
        .o_next_pc     (next_pc),
        .o_pc_hold     (hold),
        .o_flush       (flush),
        .o_epc         (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] next_pc;
        logic        hold;
        logic        flush;
        logic [31:0] epc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: in boot, a flush pending this cycle, and the saved exception PC.
    bit          m_boot = 1'b1;
    bit          m_flush = 1'b0;
    logic [31:0] m_epc = 32'h0;
    logic [31:0] last_exp_pc = 32'h0;

    task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.tag, "next_pc", next_pc, e.next_pc);
            cmp(e.tag, "pc_hold", {31'h0, hold}, {31'h0, e.hold});
            cmp(e.tag, "flush", {31'h0, flush}, {31'h0, e.flush});
            cmp(e.tag, "epc", epc, e.epc);
        end
    end

    task automatic drive(input logic r, input logic [31:0] pc, input logic st,
                         input logic b, input logic [31:0] bt, input logic j,
                         input logic [31:0] jt, input logic x, input logic er,
                         input string tag);
        exp_t e;
        logic [31:0] tgt;
        bit redirect;
        @(posedge clk);
        #1;
        rst = r; cur_pc = pc; stall = st; br = b; br_tgt = bt;
        jmp = j; jmp_tgt = jt; exc = x; eret = er;
        if (r) begin
            m_boot = 1'b1; m_flush = 1'b0; m_epc = 32'h0;
        end
        redirect = 1'b0;
        e.hold   = 1'b0;
        if (m_boot)      tgt = RV;
        else if (x)      begin tgt = EV;    redirect = 1'b1; end
        else if (er)     begin tgt = m_epc; redirect = 1'b1; end
        else if (b)      begin tgt = bt;    redirect = 1'b1; end
        else if (j)      begin tgt = jt;    redirect = 1'b1; end
        else if (st)     begin tgt = pc;    e.hold = 1'b1; end
        else             tgt = pc + 32'd4;
        e.next_pc = tgt & 32'hFFFF_FFFC;
        e.flush   = m_flush;
        e.epc     = m_epc;
        e.tag     = tag;
        exp_q.push_back(e);
        last_exp_pc = e.next_pc;
        if (!r) begin
            if (m_boot) begin
                m_boot = 1'b0; m_flush = 1'b0;
            end else begin
                m_flush = redirect;
                if (x) m_epc = pc;
            end
        end
    endtask

    task automatic seq(input logic [31:0] pc, input string tag);
        drive(1'b0, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        drive(1'b1, 32'h1234, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, "reset_held");
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "reset_held2");
        seq(32'h0, "boot");
        seq(32'h0, "run0");
        seq(32'h4, "run1");
        seq(32'h8, "run2");
        seq(32'h3C, "pre_stall");
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "stall1");
        drive(1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "stall2");
        seq(32'h40, "post_stall");
        drive(1'b0, 32'h20, 1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0, 1'b0, "br_over_stall");
        seq(32'h100, "br_flush");
        seq(32'h104, "br_after");
        seq(32'h1FC, "pre_exc");
        drive(1'b0, 32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0, "exc");
        seq(32'h80, "exc_flush");
        seq(32'h84, "exc_run");
        drive(1'b0, 32'h88, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, "eret");
        seq(32'h200, "eret_flush");
        seq(32'hFFFF_FFFC, "wrap");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h777, 1'b0, 1'b0, "jump");
        drive(1'b0, 32'h774, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 1'b0, "jump_in_flush");
        seq(32'h900, "flush_extended");
        seq(32'h904, "flush_done");
        drive(1'b0, 32'h3A0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, "exc_eret");
        seq(32'h80, "exc_eret_flush");
        drive(1'b0, 32'h84, 1'b0, 1'b1, 32'h440, 1'b0, 32'h0, 1'b0, 1'b0, "br_pre_rst");
        drive(1'b1, 32'h440, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, "rst_in_flush");
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 1'b0, "boot_ignores");
        seq(32'h0, "after_boot");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 1) == 0) ? last_exp_pc : $urandom;
            drive(($urandom_range(0, 39) == 0), pc,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), $urandom,
                  ($urandom_range(0, 6) == 0), $urandom,
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) == 0), "random");
        end
        seq(last_exp_pc, "tail");

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter EXC_VECTOR, default 32'h0000_0080, the exception handler entry address.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_cur_pc, input, 32 bits: current PC register value.
REQ-006 The block SHALL have port i_stall, input, 1 bit: hazard stall request.
REQ-007 The block SHALL have ports i_br_taken (input, 1 bit) and i_br_target (input, 32 bits): resolved taken branch and its target.
REQ-008 The block SHALL have ports i_jump (input, 1 bit) and i_jump_target (input, 32 bits): jump and its target.
REQ-009 The block SHALL have port i_exc, input, 1 bit: exception raised.
REQ-010 The block SHALL have port i_eret, input, 1 bit: return from exception.
REQ-011 The block SHALL have port o_next_pc, output, 32 bits: value the PC register loads at the next edge.
REQ-012 The block SHALL have port o_pc_hold, output, 1 bit: 1 = PC register holds its value, 0 = PC register loads o_next_pc.
REQ-013 The block SHALL have port o_flush, output, 1 bit: kill the instruction fetched on the wrong path.
REQ-014 The block SHALL have port o_epc, output, 32 bits: saved exception PC.

Function
REQ-015 The FSM SHALL have states BOOT, RUN and FLUSH; reset enters BOOT.
REQ-016 BOOT: o_next_pc = RESET_VECTOR, o_pc_hold = 0, o_flush = 0; the FSM SHALL move to RUN unconditionally after one cycle, ignoring all requests.
REQ-017 In RUN and FLUSH, o_next_pc SHALL be selected combinationally with fixed priority: i_exc > i_eret > i_br_taken > i_jump > i_stall > sequential.
- exc: EXC_VECTOR
- eret: o_epc
- branch: i_br_target
- jump: i_jump_target
- stall: i_cur_pc with o_pc_hold = 1
- sequential: i_cur_pc + 4
REQ-018 Sequential increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 Bits [1:0] of o_next_pc SHALL be zero for every source; misaligned targets are silently truncated.
REQ-020 A redirect (exc, eret, branch or jump) SHALL override a simultaneous i_stall and force o_pc_hold = 0.
REQ-021 A redirect SHALL move the FSM to FLUSH for exactly one cycle; o_flush SHALL be high only in FLUSH (registered, one cycle after the redirect).
REQ-022 A redirect arriving while in FLUSH SHALL be accepted (same priority) and SHALL keep the FSM in FLUSH for one further cycle.
REQ-023 On an accepted i_exc, o_epc SHALL load i_cur_pc at the same edge; o_epc SHALL be unchanged otherwise, including on i_eret.
REQ-024 i_exc together with i_eret SHALL act as an exception only; o_epc SHALL not be read for the redirect in that case.
REQ-025 The block SHALL be fully combinational from inputs to o_next_pc and o_pc_hold, adding zero cycles of latency to a redirect.

Reset
REQ-026 While i_rst is high: state = BOOT, o_flush = 0, o_epc = 0, o_next_pc = RESET_VECTOR, o_pc_hold = 0.
REQ-027 Assertion of i_rst mid-redirect or mid-FLUSH SHALL abort it immediately; no epc update SHALL occur at or after the reset edge.

Structure
REQ-028 State encodings and the default RESET_VECTOR and EXC_VECTOR constants SHALL live in the shared CPU package.
REQ-029 The next-PC priority mux SHALL be one sub-module, pc_next_mux (combinational); the FSM and the epc register SHALL reside in pc_sequencer.

Verification
REQ-030 The bench SHALL cover: reset release, then three clean RUN cycles with i_cur_pc following -> o_next_pc = 0, 4, 8, 0xC; o_flush = 0 throughout.
REQ-031 The bench SHALL cover: i_stall high for 2 cycles at i_cur_pc = 0x40 -> o_pc_hold = 1 and o_next_pc = 0x40 both cycles, then 0x44.
REQ-032 The bench SHALL cover: i_br_taken with i_br_target = 0x103 and i_stall both high at pc 0x20 -> o_next_pc = 0x100, o_pc_hold = 0; o_flush = 1 on the next cycle only.
REQ-033 The bench SHALL cover: i_exc at pc 0x200 -> o_next_pc = 0x80; o_epc = 0x200 after the edge; a later i_eret -> o_next_pc = 0x200.
REQ-034 The bench SHALL cover: sequential at i_cur_pc = 0xFFFF_FFFC -> o_next_pc = 0x0000_0000.
REQ-035 The bench SHALL cover: i_rst pulsed during FLUSH -> o_flush = 0 immediately; o_epc = 0; state = BOOT.
